// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
//   - default parameter values (reset PC / ROM base, ROM depth, queue depth)
//   - NOP_INSTR: word carried by fetch-address-error entries
//   - fq_entry_t: one fetch-queue entry {pc[31:0], instr[31:0], adel} = 65 bits
//   - fetch_state_t: fetch run / error-locked state
//   - addr_err(): fetch address error check
package fetch_ctrl_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam int          IM_WORDS_DEF = 1024;
    localparam int          FQ_DEPTH_DEF = 2;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fq_entry_t;

    localparam int FQ_ENTRY_W = $bits(fq_entry_t);

    // FS_LOCKED: an address-error entry has been queued; fetch is frozen
    // until the next redirect.
    typedef enum logic {
        FS_RUN    = 1'b0,
        FS_LOCKED = 1'b1
    } fetch_state_t;

    // Misaligned, or outside [base, base + 4*words). The offset is an
    // unsigned 32-bit subtract, so addresses below base wrap to a huge
    // offset and are flagged as well.
    function automatic logic addr_err(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input int unsigned words);
        logic [31:0] off;
        logic [31:0] span;
        off  = pc - base;
        span = 32'(words) << 2;
        return (pc[1:0] != 2'b00) || (off >= span);
    endfunction

endpackage

// File: rtl/fetch_ctrl_queue.sv
// Synchronous FIFO used as the fetch queue.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   push_i / din_i      enqueue din_i (ignored when full unless popping)
//   pop_i               dequeue the head (ignored when empty)
//   flush_i             drop all entries, reset pointers; wins over push/pop
//   dout_o              head entry; holds the last shown entry while empty
//   empty_o, count_o    occupancy
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_ctrl_queue #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] hold_q,   hold_d;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees a slot, so a full queue still streams.
    assign do_push = push_i & ~flush_i & (~full | pop_i);
    assign do_pop  = pop_i & ~flush_i & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
        // Remember what is on the output so it stays stable once empty.
        if (!empty) hold_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted in.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = empty ? hold_q : mem_q[rd_ptr_q];
    assign empty_o = empty;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller for a single-port combinational instruction
// ROM. Owns the PC, drives the ROM address every cycle and queues
// {pc, instr, adel} entries for decode.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   im_pc / im_ir      ROM address (= pc) and same-cycle ROM data
//   redirect_valid/pc  taken branch/jump: flush queue, load new pc
//   out_valid/ready    handshake to decode; transfer when both high and no
//                      redirect is flushing the queue in that cycle
//   out_instr/pc/adel  head entry; instr is zero on address-error entries
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF,
    parameter int          FQ_DEPTH = FQ_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] im_pc,
    input  logic [31:0] im_ir,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_adel
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [31:0]  pc_q, pc_d;
    fetch_state_t state_q, state_d;

    logic         fq_empty;
    logic [CW-1:0] fq_count;
    fq_entry_t    fq_din;
    fq_entry_t    fq_dout;
    logic         adel;
    logic         push;
    logic         pop;

    assign im_pc = pc_q;
    assign adel  = addr_err(pc_q, PC_RESET, IM_WORDS);

    // Redirect discards the head in the same cycle, so no transfer happens.
    assign pop  = ~fq_empty & out_ready & ~redirect_valid;
    assign push = ~redirect_valid & (state_q == FS_RUN) &
                  ((fq_count < CW'(FQ_DEPTH)) | pop);

    always_comb begin
        fq_din.pc    = pc_q;
        fq_din.instr = adel ? NOP_INSTR : im_ir;
        fq_din.adel  = adel;
    end

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = FS_RUN;
        end else if (push) begin
            pc_d = pc_q + 32'd4;
            if (adel) state_d = FS_LOCKED;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= PC_RESET;
            state_q <= FS_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_ctrl_queue #(
        .WIDTH (FQ_ENTRY_W),
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .din_i   (fq_din),
        .dout_o  (fq_dout),
        .empty_o (fq_empty),
        .count_o (fq_count)
    );

    assign out_valid = ~fq_empty;
    assign out_pc    = fq_dout.pc;
    assign out_instr = fq_dout.instr;
    assign out_adel  = fq_dout.adel;

endmodule
